// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, early exit when the remaining bits are zero.
// Optional signed operands are enabled by defining SIGNED_MODE_EN, which adds the signed_op port.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_MODE_EN
    input  logic                 signed_op,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mreg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     a_mag_d, b_mag_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   product_d;

`ifdef SIGNED_MODE_EN
    logic sop_q;
    logic neg_q;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude unsigned.
    always_comb begin
        a_mag_d = (sop_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
        b_mag_d = (sop_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
        product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
    end
`else
    always_comb begin
        a_mag_d   = a_q;
        b_mag_d   = b_q;
        product_d = acc_q;
    end
`endif

    assign acc_d = mreg_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            mreg_q    <= '0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef SIGNED_MODE_EN
            sop_q     <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
`ifdef SIGNED_MODE_EN
                        sop_q   <= signed_op;
`endif
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    mcand_q <= {{WIDTH{1'b0}}, a_mag_d};
                    mreg_q  <= b_mag_d;
                    acc_q   <= '0;
`ifdef SIGNED_MODE_EN
                    neg_q   <= sop_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`endif
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    // Exit as soon as no multiplier bits remain; acc already holds the result.
                    if (mreg_q == '0) begin
                        product_q <= product_d;
                        state_q   <= S_DONE;
                    end else begin
                        acc_q   <= acc_d;
                        mcand_q <= mcand_q << 1;
                        mreg_q  <= mreg_q >> 1;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state_q == S_LOAD) || (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: cycle-level reference model plus directed vectors with literal expectations.
module tb_seq_shift_add_multiplier;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
`ifdef SIGNED_MODE_EN
    logic           signed_op = 1'b0;
`endif
    logic           busy, done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_fail = 0;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SIGNED_MODE_EN
        .signed_op(signed_op),
`endif
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sig_bits(input int v);
        int p = 0;
        while (v != 0) begin p++; v = v >>> 1; end
        return p;
    endfunction

    // Reference model: k is the 1-based cycle index within an operation (0 = idle),
    // lat is the cycle in which done is expected, product follows the math result.
    int             m_k = 0;
    int             m_lat = 0;
    logic [2*W-1:0] m_pend = '0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_lat = 0; m_pend = '0; m_prod = '0;
        end else if (m_k == 0) begin
            if (start) begin
                int sa, sb;
                sa = int'(a); sb = int'(b);
`ifdef SIGNED_MODE_EN
                if (signed_op) begin sa = int'($signed(a)); sb = int'($signed(b)); end
`endif
                m_pend = 16'(sa * sb);
                m_lat  = 3 + sig_bits(sb < 0 ? -sb : sb);
                m_k    = 1;
            end
        end else if (m_k == m_lat) begin
            m_k = 0;
        end else begin
            m_k++;
            if (m_k == m_lat) m_prod = m_pend;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("model_busy", 32'(busy), 32'(m_k >= 1 && m_k < m_lat));
            check("model_done", 32'(done), 32'(m_k != 0 && m_k == m_lat));
            check("model_product", 32'(product), 32'(m_prod));
            if (busy && done) check("busy_done_excl", 1, 0);
        end
    end

    // Launch one operation and wait for done; checks done cycle and product against literals.
    // pulse_at > 0 re-asserts start for one cycle at that cycle with junk operands.
    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int exp_prod, input int exp_cyc, input int pulse_at);
        int cyc;
        @(negedge clk);
        start = 1'b1; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; a = 8'hA5; b = 8'h3C;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == pulse_at) begin start = 1'b1; a = 8'd100; b = 8'd100; end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({name, "_product"}, 32'(product), 32'(exp_prod));
        @(negedge clk);
        check({name, "_idle_after"}, 32'({busy, done}), 32'd0);
        check({name, "_product_held"}, 32'(product), 32'(exp_prod));
    endtask

    initial begin
        int done_cyc[$];
        int idle_between;
        bit seen_first;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_product", 32'(product), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("13x5", 8'd13, 8'd5, 65, 6, 0);
        run_op("255x255", 8'd255, 8'd255, 65025, 11, 0);
        run_op("200x0", 8'd200, 8'd0, 0, 3, 0);
        run_op("7x0", 8'd7, 8'd0, 0, 3, 0);
        run_op("1x128", 8'd1, 8'd128, 128, 11, 0);
        run_op("3x9_pulse", 8'd3, 8'd9, 27, 7, 3);

        // start held high: done pulses 6 cycles apart with a single idle cycle between
        @(negedge clk);
        start = 1'b1; a = 8'd2; b = 8'd3;
        idle_between = 0; seen_first = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                if (done_cyc.size() == 0) seen_first = 1;
                done_cyc.push_back(c);
                check("b2b_product", 32'(product), 6);
            end else if (!busy && seen_first && done_cyc.size() == 1) begin
                idle_between++;
            end
        end
        start = 1'b0;
        check("b2b_pulse_count", 32'(done_cyc.size()), 2);
        if (done_cyc.size() >= 2) check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 6);
        check("b2b_idle_cycles", 32'(idle_between), 1);
        repeat (12) @(negedge clk);

        // asynchronous reset mid-CALC after a completed 65
        run_op("pre_reset", 8'd13, 8'd5, 65, 6, 0);
        start = 1'b1; a = 8'd200; b = 8'd255;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(done), 0);
        check("rst_mid_product", 32'(product), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("4x4_after_reset", 8'd4, 8'd4, 16, 6, 0);

`ifdef SIGNED_MODE_EN
        signed_op = 1'b1;
        run_op("s_m3x5", 8'hFD, 8'd5, 16'hFFF1, 6, 0);
        run_op("s_m128xm128", 8'h80, 8'h80, 16384, 11, 0);
        run_op("s_7xm1", 8'd7, 8'hFF, 16'hFFF9, 4, 0);
        signed_op = 1'b0;
        run_op("u_253x5", 8'hFD, 8'd5, 1265, 6, 0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential multiplier. Successor to the fixed repeated-addition multiply controller.
- Shift-add datapath processes one multiplier bit per cycle and exits early once the remaining multiplier bits are zero.
- Includes a start/busy/done handshake and a held result register.
- Sits behind a bus-side register block; used wherever a low-area multiply is acceptable.

Parameters:
- WIDTH, 8: operand width in bits (must be ≥ 2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand; sampled on the accepting start edge
- b  input  WIDTH  multiplier; sampled on the accepting start edge
- busy  output  1  high in LOAD and CALC
- done  output  1  single-cycle pulse in DONE
- product  output  2*WIDTH  last result; held until the next DONE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, busy=0, done=0, product=0, all internal registers 0.
  - Reset mid-operation aborts the operation; product returns to 0, not the previous result.
- Internal registers:
  - mcand: 2*WIDTH bits.
  - mreg: WIDTH bits.
  - acc: 2*WIDTH bits.
- State machine:
  - IDLE: if start=1 → LOAD, and capture a, b into staging registers. Otherwise stay in IDLE.
  - LOAD (1 cycle): mcand={WIDTH zeros, a}, mreg=b, acc=0; → CALC.
  - CALC (per cycle):
    - If mreg==0: → DONE, and product<=acc on this edge.
    - Else: if mreg[0], acc<=acc+mcand; mcand<=mcand<<1; mreg<=mreg>>1. Stay in CALC.
  - DONE (1 cycle): done=1; → IDLE.
- Arithmetic: all additions are 2*WIDTH bits with no overflow. The maximum product (2^W−1)^2 fits in 2*WIDTH bits.
- Latency:
  - Let p = number of significant bits of b: p = floor(log2 b)+1, and p=0 for b=0.
  - CALC lasts p+1 cycles.
  - done is high in cycle 3+p after the accepting start edge (1-indexed, counting the LOAD cycle as cycle 1).
  - Minimum 3 cycles (b=0). Maximum WIDTH+3 cycles.
- Handshake:
  - start is ignored in LOAD, CALC and DONE; it is not queued.
  - start held high through DONE is accepted on the first IDLE edge, giving back-to-back operations with one IDLE cycle between them.
  - a and b may change freely after the accepting edge.
- product changes only on the CALC→DONE edge. It is stable while done=1 and stays stable afterwards until the next operation completes.
- busy and done are never high in the same cycle.
- Outputs are registered or decoded from state only; no combinational path from start to busy or done.

Optional Feature:
- Macro: SIGNED_MODE_EN.
- With the macro defined:
  - Adds input port signed_op (1 bit), sampled with a and b.
  - When signed_op=1:
    - LOAD loads |a| and |b| as WIDTH-bit unsigned magnitudes. The most negative value maps to 2^(WIDTH−1).
    - The sign flag is a[W−1]^b[W−1].
    - On the CALC→DONE edge, product<=−acc (two's complement, 2*WIDTH bits) if the flag is set, else acc.
    - Latency uses p of |b|.
  - When signed_op=0: identical to the unsigned behaviour.
- Without the macro: no signed_op port; unsigned only; no negation logic.

Test Plan:
- WIDTH=8, a=13, b=5 → done in cycle 6 after start; product=65; busy high in cycles 1–5.
- a=255, b=255 → done in cycle 11 (maximum latency); product=65025.
- b=0, a=200 → done in cycle 3; product=0.
- a=7, b=0 → done in cycle 3; product=0.
- start pulsed again during CALC of a=3, b=9 → ignored; product=27, then the core returns to IDLE.
- start held high continuously with a=2, b=3 → consecutive done pulses; each product=6; exactly one IDLE cycle between operations.
- rst_n asserted low mid-CALC after a previous product=65 → busy=0, done=0, product=0 immediately (asynchronous). After rst_n is released, a new start with a=4, b=4 gives product=16.
- SIGNED_MODE_EN with signed_op=1:
  - a=−3 (0xFD), b=5 → product=0xFFF1 (−15).
  - a=−128, b=−128 → product=16384.
  - With signed_op=0, a=0xFD, b=5 → product=1265.
